// File: rtl/vp_pkg.sv
// ---------------------------------------------------------------------------
// vp_pkg
// Shared defaults for the camera-to-DSP pixel path: data/counter widths,
// blanking-based sync timing and the VS source selection encoding.
// ---------------------------------------------------------------------------
package vp_pkg;

  // Widths
  localparam int unsigned DW_DEF       = 10;    // pixel data
  localparam int unsigned FW_DEF       = 8;     // frame counter (FW <= DW)
  localparam int unsigned TAG_LEN_DEF  = 20;    // tagged pixels per line
  localparam int unsigned PW_DEF       = 10;    // pixel counter
  localparam int unsigned BW_DEF       = 20;    // blanking counter

  // Sync timing, counted in blanking cycles
  localparam int unsigned HS_START_DEF = 8;
  localparam int unsigned HS_WIDTH_DEF = 128;
  localparam int unsigned VS_START_DEF = 9408;
  localparam int unsigned VS_END_DEF   = 15680;

  // Source of vs_out
  typedef enum logic {
    VS_PASS  = 1'b0,  // registered copy of the sensor VS
    VS_REGEN = 1'b1   // regenerated from the blanking length
  } vs_mode_e;

endpackage

// File: rtl/vp_frame_tagger_if.sv
// ---------------------------------------------------------------------------
// vp_frame_tagger_if
// Video-port bundle: sensor side (vpd_in/href_in/vs_in) and DSP side
// (vpd_out/href_out/vs_out/hs_out).
//   slave  : the tagger's view (consumes sensor signals, drives DSP signals)
//   master : the environment's view (drives sensor signals, observes DSP side)
// ---------------------------------------------------------------------------
interface vp_frame_tagger_if #(
  parameter int unsigned DW = vp_pkg::DW_DEF
);

  logic [DW-1:0] vpd_in;
  logic          href_in;
  logic          vs_in;
  logic [DW-1:0] vpd_out;
  logic          href_out;
  logic          vs_out;
  logic          hs_out;

  modport slave (
    input  vpd_in, href_in, vs_in,
    output vpd_out, href_out, vs_out, hs_out
  );

  modport master (
    output vpd_in, href_in, vs_in,
    input  vpd_out, href_out, vs_out, hs_out
  );

endinterface

// File: rtl/vp_sync_gen.sv
// ---------------------------------------------------------------------------
// vp_sync_gen
// Counts horizontal-blanking cycles (href low) and derives HS (active low)
// and an internal VS pulse from fixed windows of that count.
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   i_href     : sensor line-valid; clears the blanking count while high
//   o_hs       : registered HS, low while HS_START <= count < HS_START+HS_WIDTH
//   o_vs       : registered VS, high while VS_START <= count < VS_END
// ---------------------------------------------------------------------------
module vp_sync_gen
  import vp_pkg::*;
#(
  parameter int unsigned BW       = BW_DEF,
  parameter int unsigned HS_START = HS_START_DEF,
  parameter int unsigned HS_WIDTH = HS_WIDTH_DEF,
  parameter int unsigned VS_START = VS_START_DEF,
  parameter int unsigned VS_END   = VS_END_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_href,
  output logic o_hs,
  output logic o_vs
);

  logic [BW-1:0] r_blank_cnt;
  logic          r_hs;
  logic          r_vs;
  logic [31:0]   w_blank;
  logic          w_hs_win;
  logic          w_vs_win;

  // Compare in 32 bits so window limits beyond 2^BW simply never match.
  assign w_blank  = 32'(r_blank_cnt);
  assign w_hs_win = (w_blank >= HS_START) && (w_blank < HS_START + HS_WIDTH);
  assign w_vs_win = (w_blank >= VS_START) && (w_blank < VS_END);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blank_cnt <= '0;
      r_hs        <= 1'b1;
      r_vs        <= 1'b0;
    end else begin
      // Saturate instead of wrapping: a stalled sensor must not retrigger sync.
      if (i_href)
        r_blank_cnt <= '0;
      else if (r_blank_cnt != '1)
        r_blank_cnt <= r_blank_cnt + BW'(1);
      r_hs <= ~w_hs_win;
      r_vs <= w_vs_win;
    end
  end

  assign o_hs = r_hs;
  assign o_vs = r_vs;

endmodule

// File: rtl/vp_frame_tagger.sv
// ---------------------------------------------------------------------------
// vp_frame_tagger
// Pixel path between sensor and DSP with one registered cycle of latency.
// Regenerates HS (and VS when VS_MODE = VS_REGEN) from the blanking length
// and overwrites the first TAG_LEN pixels of each line with the frame number,
// left-justified, so the DSP can detect dropped or repeated frames.
//
// Ports:
//   clk       pixel clock (sensor PCLK)
//   nReset    asynchronous active-low reset; release is expected to be
//             synchronised to clk by the system reset logic
//   vp        video-port bundle (slave modport): vpd/href/vs in,
//             vpd/href/vs/hs out
//   tag_en    1 = insert tag, 0 = pure data passthrough
//   fsin_out  frame-sync to the sensor, tied low
//   frame_cnt current frame number (debug)
//
// Build option VP_LINE_TAG_EN: adds a DW-bit line counter (cleared on the VS
// rising edge, incremented on each href rising edge) that is written into
// pixels TAG_LEN .. 2*TAG_LEN-1 of each line while tag_en = 1. PW must then
// be large enough to count to 2*TAG_LEN.
// ---------------------------------------------------------------------------
module vp_frame_tagger
  import vp_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned FW       = FW_DEF,
  parameter int unsigned TAG_LEN  = TAG_LEN_DEF,
  parameter int unsigned PW       = PW_DEF,
  parameter int unsigned BW       = BW_DEF,
  parameter int unsigned HS_START = HS_START_DEF,
  parameter int unsigned HS_WIDTH = HS_WIDTH_DEF,
  parameter int unsigned VS_START = VS_START_DEF,
  parameter int unsigned VS_END   = VS_END_DEF,
  parameter vs_mode_e    VS_MODE  = VS_REGEN
) (
  input  logic                    clk,
  input  logic                    nReset,
  vp_frame_tagger_if.slave        vp,
  input  logic                    tag_en,
  output logic                    fsin_out,
  output logic [FW-1:0]           frame_cnt
);

  logic [PW-1:0] r_pix_cnt;
  logic [FW-1:0] r_frame_cnt;
  logic [DW-1:0] r_vpd;
  logic          r_href;
  logic          r_vs_pass;
  logic          r_vs_q;

  logic          w_hs;
  logic          w_vs_int;
  logic          w_vs_sel;
  logic          w_vs_rise;
  logic          w_tag_win;
  logic [DW-1:0] w_frame_tag;
  logic [DW-1:0] w_vpd_next;

  vp_sync_gen #(
    .BW       (BW),
    .HS_START (HS_START),
    .HS_WIDTH (HS_WIDTH),
    .VS_START (VS_START),
    .VS_END   (VS_END)
  ) u_sync_gen (
    .clk    (clk),
    .rst_n  (nReset),
    .i_href (vp.href_in),
    .o_hs   (w_hs),
    .o_vs   (w_vs_int)
  );

  // Both sources are already registered, so vs_out keeps the 1-cycle latency.
  assign w_vs_sel  = (VS_MODE == VS_REGEN) ? w_vs_int : r_vs_pass;
  assign w_vs_rise = w_vs_sel & ~r_vs_q;

  // pix_cnt is 0 on the first active pixel because it is held clear in blanking.
  assign w_tag_win   = vp.href_in && (r_pix_cnt < PW'(TAG_LEN));
  assign w_frame_tag = DW'(r_frame_cnt) << (DW - FW);

`ifdef VP_LINE_TAG_EN
  logic [DW-1:0] r_line_cnt;
  logic          w_line_win;

  assign w_line_win = vp.href_in && (r_pix_cnt >= PW'(TAG_LEN))
                      && (r_pix_cnt < PW'(2 * TAG_LEN));

  // r_href is the previous href_in, so href_in & ~r_href marks a line start.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)
      r_line_cnt <= '0;
    else if (w_vs_rise)
      r_line_cnt <= '0;
    else if (vp.href_in && !r_href)
      r_line_cnt <= r_line_cnt + DW'(1);
  end
`endif

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_vpd_next = vp.vpd_in;
    if (tag_en && w_tag_win)
      w_vpd_next = w_frame_tag;
`ifdef VP_LINE_TAG_EN
    else if (tag_en && w_line_win)
      w_vpd_next = r_line_cnt;
`endif
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_pix_cnt   <= '0;
      r_frame_cnt <= '0;
      r_vpd       <= '0;
      r_href      <= 1'b0;
      r_vs_pass   <= 1'b0;
      r_vs_q      <= 1'b0;
    end else begin
      if (!vp.href_in)
        r_pix_cnt <= '0;
      else if (r_pix_cnt != '1)
        r_pix_cnt <= r_pix_cnt + PW'(1);

      // The tag above already used the pre-increment frame number this cycle.
      if (w_vs_rise)
        r_frame_cnt <= r_frame_cnt + FW'(1);

      r_vpd     <= w_vpd_next;
      r_href    <= vp.href_in;
      r_vs_pass <= vp.vs_in;
      r_vs_q    <= w_vs_sel;
    end
  end

  assign vp.vpd_out  = r_vpd;
  assign vp.href_out = r_href;
  assign vp.vs_out   = w_vs_sel;
  assign vp.hs_out   = w_hs;
  assign fsin_out    = 1'b0;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vp_frame_tagger.sv
// ---------------------------------------------------------------------------
// tb_vp_frame_tagger
// Two taggers share one stimulus stream: one regenerates VS from blanking,
// the other passes vs_in through (fast frame counting). The blanking counter
// is narrowed to 14 bits so its saturation is reachable in a short run.
// A per-cycle reference model pushes expected outputs into a scoreboard
// when inputs are applied; they are popped and compared after the edge.
// ---------------------------------------------------------------------------
module tb_vp_frame_tagger;
  import vp_pkg::*;

  localparam int unsigned DW      = 10;
  localparam int unsigned FW      = 8;
  localparam int unsigned TAG_LEN = 20;
  localparam int unsigned PW      = 10;
  localparam int unsigned BW      = 14;
  localparam int unsigned PIX_MAX = (1 << PW) - 1;
  localparam int unsigned BLK_MAX = (1 << BW) - 1;

  typedef struct packed {
    logic [15:0]   pix;
    logic [31:0]   blank;
    logic          hs;
    logic          vs_int;
    logic          vs_pass;
    logic          vs_q;
    logic [FW-1:0] frame;
    logic [DW-1:0] line;
    logic          href_q;
    logic [DW-1:0] vpd;
  } model_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] vpd_in = '0;
  logic href_in = 1'b0;
  logic vs_in = 1'b0;
  logic tag_en = 1'b0;

  logic          fsin_r, fsin_p;
  logic [FW-1:0] frame_r, frame_p;

  int n_total = 0;
  int n_bad   = 0;

  model_t m_r, m_p;
  logic [63:0] q_r[$];
  logic [63:0] q_p[$];

  always #5 clk = ~clk;

  vp_frame_tagger_if #(.DW(DW)) rif ();
  vp_frame_tagger_if #(.DW(DW)) pif ();

  assign rif.vpd_in  = vpd_in;
  assign rif.href_in = href_in;
  assign rif.vs_in   = vs_in;
  assign pif.vpd_in  = vpd_in;
  assign pif.href_in = href_in;
  assign pif.vs_in   = vs_in;

  vp_frame_tagger #(.DW(DW), .FW(FW), .TAG_LEN(TAG_LEN), .PW(PW), .BW(BW),
                    .VS_MODE(VS_REGEN)) dut_regen (
    .clk(clk), .nReset(rst_n), .vp(rif), .tag_en(tag_en),
    .fsin_out(fsin_r), .frame_cnt(frame_r));

  vp_frame_tagger #(.DW(DW), .FW(FW), .TAG_LEN(TAG_LEN), .PW(PW), .BW(BW),
                    .VS_MODE(VS_PASS)) dut_pass (
    .clk(clk), .nReset(rst_n), .vp(pif), .tag_en(tag_en),
    .fsin_out(fsin_p), .frame_cnt(frame_p));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, from the current inputs.
  function automatic model_t model_step(input model_t s, input vs_mode_e mode);
    model_t n;
    logic   vs_now;
    if (!rst_n) begin
      n    = '0;
      n.hs = 1'b1;
      return n;
    end
    n        = s;
    n.pix    = !href_in ? 16'd0 : (s.pix == PIX_MAX[15:0]) ? s.pix : s.pix + 16'd1;
    n.blank  = href_in ? 32'd0 : (s.blank == BLK_MAX) ? s.blank : s.blank + 32'd1;
    n.hs     = !(s.blank >= 8 && s.blank < 8 + 128);
    n.vs_int = (s.blank >= 9408 && s.blank < 15680);
    n.vs_pass = vs_in;
    vs_now   = (mode == VS_REGEN) ? s.vs_int : s.vs_pass;
    n.vs_q   = vs_now;
    if (vs_now && !s.vs_q) n.frame = s.frame + 8'd1;
    if (vs_now && !s.vs_q)       n.line = '0;
    else if (href_in && !s.href_q) n.line = s.line + 10'd1;
    n.href_q = href_in;
    n.vpd    = vpd_in;
    if (tag_en && href_in && s.pix < TAG_LEN) n.vpd = {s.frame, 2'b00};
`ifdef VP_LINE_TAG_EN
    else if (tag_en && href_in && s.pix >= TAG_LEN && s.pix < 2 * TAG_LEN) n.vpd = s.line;
`endif
    return n;
  endfunction

  function automatic logic [63:0] exp_of(input model_t m, input vs_mode_e mode);
    return 64'({m.vpd, m.href_q, (mode == VS_REGEN) ? m.vs_int : m.vs_pass, m.hs, m.frame});
  endfunction

  // One clock: model and push at the falling edge, pop and compare after the rising edge.
  task automatic tick();
    @(negedge clk);
    m_r = model_step(m_r, VS_REGEN);
    m_p = model_step(m_p, VS_PASS);
    q_r.push_back(exp_of(m_r, VS_REGEN));
    q_p.push_back(exp_of(m_p, VS_PASS));
    @(posedge clk);
    #1;
    check("regen_out", 64'({rif.vpd_out, rif.href_out, rif.vs_out, rif.hs_out, frame_r}),
          q_r.pop_front());
    check("pass_out", 64'({pif.vpd_out, pif.href_out, pif.vs_out, pif.hs_out, frame_p}),
          q_p.pop_front());
  endtask

  task automatic line(input int n, input logic [DW-1:0] d);
    href_in = 1'b1;
    vpd_in  = d;
    for (int i = 0; i < n; i++) tick();
    href_in = 1'b0;
  endtask

  task automatic blank(input int n);
    href_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic vs_toggle();
    vs_in = 1'b1; tick();
    vs_in = 1'b0; tick();
  endtask

  initial begin
    int tag_cnt, plain_cnt, low_cnt, first_low, hi_cnt, rises;
    logic prev_vs;
    m_r = '0; m_r.hs = 1'b1;
    m_p = '0; m_p.hs = 1'b1;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      vpd_in  = DW'($urandom);
      href_in = 1'($urandom);
      vs_in   = 1'($urandom);
      tag_en  = 1'($urandom);
      tick();
    end
    check("rst_hs", 64'(rif.hs_out), 64'd1);
    check("rst_vs", 64'(rif.vs_out), 64'd0);
    check("rst_vpd", 64'(rif.vpd_out), 64'd0);
    check("rst_frame", 64'(frame_r), 64'd0);
    check("rst_fsin", 64'(fsin_r), 64'd0);

    // Release: first pixel passes through, then frame-0 tag
    rst_n = 1'b1; vs_in = 1'b0; tag_en = 1'b0;
    href_in = 1'b1; vpd_in = 10'h3FF;
    tick();
    check("rel_pass", 64'(rif.vpd_out), 64'h3FF);
    tag_en = 1'b1;
    tick();
    check("rel_tag0", 64'(rif.vpd_out), 64'h000);
    blank(4);

    // Bring the passthrough-VS tagger to frame 0x5A
    for (int i = 0; i < 'h5A; i++) vs_toggle();
    tick();
    check("frame_5a", 64'(frame_p), 64'h5A);

    // 640-pixel line with and without tagging
    for (int pass = 0; pass < 2; pass++) begin
      tag_en = (pass == 0);
      tag_cnt = 0; plain_cnt = 0;
      href_in = 1'b1; vpd_in = 10'h155;
      for (int i = 0; i < 640; i++) begin
        tick();
        if (pif.vpd_out == 10'h168) tag_cnt++;
        else if (pif.vpd_out == 10'h155) plain_cnt++;
      end
      check(pass == 0 ? "tag_on_cnt" : "tag_off_cnt", 64'(tag_cnt), pass == 0 ? 64'd20 : 64'd0);
      check(pass == 0 ? "plain_on_cnt" : "plain_off_cnt", 64'(plain_cnt), pass == 0 ? 64'd620 : 64'd640);
    end
    tag_en = 1'b1;

    // HS: 200-cycle blank
    line(8, 10'h0AA);
    low_cnt = 0; first_low = -1;
    href_in = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!rif.hs_out) begin
        low_cnt++;
        if (first_low < 0) first_low = i;
      end
    end
    check("hs_width", 64'(low_cnt), 64'd128);
    check("hs_start", 64'(first_low), 64'd8);

    // Truncated blank, then a line
    line(50, 10'h0AA);
    blank(100);
    line(50, 10'h123);

    // VS regeneration
    hi_cnt = 0;
    href_in = 1'b0;
    for (int i = 0; i < 16000; i++) begin
      tick();
      if (rif.vs_out) hi_cnt++;
    end
    check("vs_width", 64'(hi_cnt), 64'd6272);
    line(30, 10'h155);
    check("frame_regen1", 64'(frame_r), 64'h01);

    // Frame counter wrap on the passthrough-VS tagger
    for (int i = 0; i < 165; i++) vs_toggle();
    check("frame_ff", 64'(frame_p), 64'hFF);
    vs_toggle();
    check("frame_wrap", 64'(frame_p), 64'h00);
    line(10, 10'h155);

    // Long stall: blanking counter saturates, one VS pulse only
    rises = 0; prev_vs = rif.vs_out;
    href_in = 1'b0;
    for (int i = 0; i < (1 << BW) + 10; i++) begin
      tick();
      if (rif.vs_out && !prev_vs) rises++;
      prev_vs = rif.vs_out;
    end
    check("vs_sat_pulses", 64'(rises), 64'd1);
    check("frame_regen2", 64'(frame_r), 64'h02);
    check("hs_sat_high", 64'(rif.hs_out), 64'd1);

    // Reset mid-line, then a fresh line tagged with frame 0
    line(30, 10'h155);
    rst_n = 1'b0; href_in = 1'b1;
    tick(); tick();
    check("midrst_frame", 64'(frame_p), 64'h00);
    rst_n = 1'b1;
    blank(3);
    tag_cnt = 0; plain_cnt = 0;
    href_in = 1'b1; vpd_in = 10'h155;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rif.vpd_out == 10'h000 && pif.vpd_out == 10'h000) tag_cnt++;
    end
    check("midrst_tag0", 64'(tag_cnt), 64'd20);
    blank(3);

    // Three lines after a VS: pixel 25 carries the line number when enabled
    vs_toggle();
    for (int l = 1; l <= 3; l++) begin
      logic [DW-1:0] px25;
      px25 = '0;
      href_in = 1'b1; vpd_in = 10'h155;
      for (int i = 0; i < 50; i++) begin
        tick();
        if (i == 25) px25 = pif.vpd_out;
      end
      blank(5);
`ifdef VP_LINE_TAG_EN
      check("line_tag", 64'(px25), 64'(l));
`else
      check("line_px25", 64'(px25), 64'h155);
`endif
    end

    check("sb_drained", 64'(q_r.size() + q_p.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vp_frame_tagger.md
Name: vp_frame_tagger

Overview:
- Parametrised pixel-path block between the camera sensor video port and the DSP video port.
- Passes pixel data and control through with a fixed 1-cycle registered latency.
- Regenerates HS, and optionally VS, from horizontal-blanking length.
- Stamps a frame counter into the first TAG_LEN pixels of every line so the DSP can detect dropped or duplicated frames.

Parameters:
- DW, 10, pixel data width.
- FW, 8, frame counter width; must satisfy FW <= DW.
- TAG_LEN, 20, pixels per line overwritten by the frame tag; 1..2^PW-1.
- PW, 10, pixel counter width.
- BW, 20, blanking counter width.
- HS_START, 8, blanking cycle at which HS asserts (low).
- HS_WIDTH, 128, HS low width in cycles.
- VS_START, 9408, blanking cycle at which regenerated VS asserts (high).
- VS_END, 15680, blanking cycle at which regenerated VS deasserts; must satisfy VS_END > VS_START.
- VS_MODE, 1, 0 = VS passed through from vs_in, 1 = VS regenerated from blanking.

Ports:
- clk  in  1  pixel clock (sensor PCLK).
- nReset  in  1  asynchronous active-low reset.
- vpd_in  in  DW  sensor pixel data.
- href_in  in  1  sensor line-valid.
- vs_in  in  1  sensor vertical sync.
- tag_en  in  1  1 = insert tag; 0 = pure passthrough of data.
- vpd_out  out  DW  pixel data to DSP.
- href_out  out  1  registered href_in.
- vs_out  out  1  selected VS.
- hs_out  out  1  regenerated HS, active low.
- fsin_out  out  1  frame-sync to sensor; tied 0.
- frame_cnt  out  FW  current frame number, for debug.

Behaviour:
- Single clock domain: clk only. nReset is asynchronous assert, synchronous deassert at the top level.
- href is NEVER used as an asynchronous reset; all counter clears are synchronous.
- Reset values:
  - vpd_out = 0, href_out = 0, vs_out = 0, hs_out = 1, frame_cnt = 0.
  - pix_cnt = 0, blank_cnt = 0, vs_int = 0, vs_q = 0.
- Latency: every output is registered. Input sampled at edge N appears at edge N+1, for data and control alike.
- pix_cnt:
  - Clears to 0 on any cycle with href_in = 0.
  - Increments while href_in = 1; saturates at 2^PW-1, no wrap.
  - Tag window = href_in = 1 and pix_cnt < TAG_LEN.
- blank_cnt:
  - Clears to 0 on any cycle with href_in = 1.
  - Increments while href_in = 0; saturates at 2^BW-1 so a stalled sensor cannot retrigger HS or VS.
- hs_out is registered from the current blank_cnt: 0 if HS_START <= blank_cnt < HS_START+HS_WIDTH, else 1.
- vs_int is registered from the current blank_cnt: 1 if VS_START <= blank_cnt < VS_END, else 0.
- vs_out = vs_int when VS_MODE = 1; registered vs_in when VS_MODE = 0.
- Frame counter:
  - vs_q holds the previous vs_out.
  - On (vs_out = 1 and vs_q = 0), frame_cnt increments by 1 and wraps mod 2^FW.
  - The increment is synchronous in clk; no derived clocks.
- Data out:
  - If tag_en = 1 and in the tag window: vpd_out = {frame_cnt, (DW-FW) zeros}, i.e. the frame number left-justified.
  - Otherwise vpd_out = vpd_in.
- Line shorter than TAG_LEN: the whole line is tag; no error is raised.
- tag_en toggling mid-line takes effect on the next cycle; partial tags are allowed.
- Simultaneous VS rising edge and tag window: the tag uses the pre-increment frame_cnt; the new value appears from the next cycle.
- Reset mid-line: all counters return to 0 immediately. The next href rising edge starts a fresh tag window with frame 0.

Optional Feature:
- Macro: VP_LINE_TAG_EN.
- Defined:
  - Adds a line counter line_cnt (DW bits). It clears on the VS rising edge and increments on each href_in rising edge, wrapping.
  - When tag_en = 1, pixels TAG_LEN .. 2*TAG_LEN-1 of each line output line_cnt.
  - pix_cnt must reach 2*TAG_LEN, so PW is sized accordingly.
- Undefined: no line counter logic; only pixels 0..TAG_LEN-1 are tagged.

Decomposition:
- Package vp_pkg: default widths DW/FW/PW/BW, default timing constants HS_START/HS_WIDTH/VS_START/VS_END, and the VS_MODE encodings VS_PASS = 0 and VS_REGEN = 1.
- Sub-module vp_sync_gen: the blanking counter plus HS/VS window compare, outputting hs/vs_int.
- Top level: tag muxing, pixel/frame/line counters.

Test Plan:
- Reset: nReset = 0 with random inputs -> hs_out = 1, vs_out = 0, vpd_out = 0, frame_cnt = 0. After release with href = 1 and vpd_in = 0x3FF -> vpd_out = 0x3FF one cycle later (frame 0 tag = 0x000 for pixels 0..19 if tag_en = 1).
- Tagging: frame_cnt = 0x5A, tag_en = 1, 640-pixel line of vpd_in = 0x155 -> vpd_out = 0x168 for pixels 0..19, then 0x155 for pixels 20..639; with tag_en = 0, all pixels are 0x155.
- HS: href low for 200 cycles -> hs_out low for exactly 128 cycles, beginning 1 cycle after blank_cnt reaches 8. A 100-cycle blank -> HS low for only 92 cycles.
- VS and frame count (VS_MODE = 1): blank for 16000 cycles -> vs_out high for 6272 cycles and frame_cnt +1. After 256 frames, frame_cnt wraps 0xFF -> 0x00.
- Saturation and reset: href held low for 2^20+10 cycles -> exactly one VS pulse and no wrap retrigger. Asserting nReset mid-line clears pix_cnt, and the next line is tagged 0x000.
- VP_LINE_TAG_EN: three lines after VS -> pixels 20..39 carry 0x001, 0x002, 0x003 respectively.
